// File: rtl/result_drainer.sv
// result_drainer: reads N words from bram1 (addresses 0..N-1) and streams them
// in address order on a valid/ready interface with full backpressure.
// A 2-entry FIFO absorbs the one-cycle BRAM read latency. A read is issued only
// when a slot is guaranteed free, so the FIFO cannot overflow.
// Optional feature: define RESULT_DRAIN_LAST_EN to add the o_last output.
module result_drainer #(
  parameter int CNT    = 31,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run,
  input  logic [CNT-1:0]    i_num_cnt,
  output logic              o_idle,
  output logic              o_busy,
  output logic              o_done,
  output logic [AWIDTH-1:0] addr_b1,
  output logic              ce_b1,
  output logic              we_b1,
  output logic [DWIDTH-1:0] d0_b1,
  input  logic [DWIDTH-1:0] q0_b1,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DWIDTH-1:0] o_data
`ifdef RESULT_DRAIN_LAST_EN
  ,
  output logic              o_last
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic [CNT-1:0]    num;
  logic [CNT-1:0]    rd_addr;
  logic [CNT-1:0]    beat_cnt;

  logic              pend;
  logic [1:0]        occ;
  logic [DWIDTH-1:0] fifo [2];
  logic              wr_ptr;
  logic              rd_ptr;

  logic              pop;
  logic              push;
  logic              issue;
  logic              last_word;
  logic              last_beat;
  logic [2:0]        credit;

  // Handshake, credit and read-issue decisions
  always_comb begin
    pop       = (occ != 2'd0) && i_ready;
    push      = pend;
    // Entries that will be occupied next cycle if no new read is issued now.
    credit    = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    issue     = (state == S_RUN) && (rd_addr < num) && (credit < 3'd2);
    last_word = (beat_cnt == num - 1'b1);
    last_beat = (state == S_RUN) && pop && last_word;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (i_run) begin
          if (i_num_cnt != '0) state_nx = S_RUN;
          else                 state_nx = S_DONE;
        end
      end
      S_RUN: begin
        if (last_beat) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Word count latch, read address and beat counters
  always_ff @(posedge clk) begin
    if (reset) begin
      num      <= '0;
      rd_addr  <= '0;
      beat_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (i_run) begin
        num      <= i_num_cnt;
        rd_addr  <= '0;
        beat_cnt <= '0;
      end
    end else begin
      if (issue) rd_addr  <= rd_addr + 1'b1;
      if (pop)   beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Read-pending flag and 2-entry FIFO; reset drops any in-flight read data
  always_ff @(posedge clk) begin
    if (reset) begin
      pend   <= 1'b0;
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) fifo[i] <= '0;
    end else begin
      pend <= issue;
      if (push) begin
        fifo[wr_ptr] <= q0_b1;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Output drive
  always_comb begin
    o_idle  = (state == S_IDLE);
    o_busy  = (state == S_RUN);
    o_done  = (state == S_DONE);
    addr_b1 = rd_addr[AWIDTH-1:0];
    ce_b1   = issue;
    we_b1   = 1'b0;
    d0_b1   = '0;
    o_valid = (occ != 2'd0);
    o_data  = fifo[rd_ptr];
`ifdef RESULT_DRAIN_LAST_EN
    o_last  = o_valid && (state == S_RUN) && last_word;
`endif
  end

endmodule
